// File: rtl/delay_line_ctrl_pkg.sv
// Shared definitions for the programmable delay line: default sizing,
// controller state encoding and the requested-delay clamp.
package delay_line_ctrl_pkg;

    // Defaults shared by every channel instance so they all agree on sizing.
    localparam int unsigned MAX_DLY_DEF = 16;
    localparam int unsigned DLY_W_DEF   = 5;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StFlush = 2'd1,
        StFill  = 2'd2
    } state_e;

    // Force a requested delay into the legal range 1..max_dly.
    function automatic int unsigned clamp_dly(input int unsigned req,
                                              input int unsigned max_dly);
        if (req == 0) begin
            return 1;
        end else if (req > max_dly) begin
            return max_dly;
        end
        return req;
    endfunction

endpackage

// File: rtl/delay_tap_line.sv
// Shift stages with a per-stage valid shadow and a tap mux.
// Stage k (1-based) lives at index k-1.
module delay_tap_line
    import delay_line_ctrl_pkg::*;
#(
    parameter int unsigned WID     = 1,
    parameter int unsigned MAX_DLY = MAX_DLY_DEF,
    parameter int unsigned DLY_W   = DLY_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_shift,
    input  logic             i_flush,
    input  logic [WID-1:0]   i_data,
    input  logic             i_vld,
    input  logic [DLY_W-1:0] i_sel,
    output logic [WID-1:0]   o_data,
    output logic             o_vld
);

    logic [WID-1:0]     r_data [MAX_DLY];
    logic [MAX_DLY-1:0] r_vld;

    // Stage update: flush clears valids only and takes priority over shifting.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(MAX_DLY); k++) begin
                r_data[k] <= '0;
            end
            r_vld <= '0;
        end else if (i_flush) begin
            r_vld <= '0;
        end else if (i_shift) begin
            r_data[0] <= i_data;
            r_vld[0]  <= i_vld;
            for (int k = 1; k < int'(MAX_DLY); k++) begin
                r_data[k] <= r_data[k-1];
                r_vld[k]  <= r_vld[k-1];
            end
        end
    end

    // Tap mux straight from the stage registers; i_sel is 1-based.
    always_comb begin
        o_data = '0;
        o_vld  = 1'b0;
        for (int k = 0; k < int'(MAX_DLY); k++) begin
            if (i_sel == DLY_W'(k + 1)) begin
                o_data = r_data[k];
                o_vld  = r_vld[k];
            end
        end
    end

endmodule

// File: rtl/delay_line_ctrl.sv
// Run-time programmable delay line controller. Accepts a new delay over a
// valid/ready handshake, then flushes valids and refills the line so no
// stale or misaligned sample is ever presented as valid.
module delay_line_ctrl
    import delay_line_ctrl_pkg::*;
#(
    parameter int unsigned WID     = 1,
    parameter int unsigned MAX_DLY = MAX_DLY_DEF,
    parameter int unsigned DEF_DLY = 1,
    parameter int unsigned DLY_W   = DLY_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WID-1:0]   i,
    input  logic             i_vld,
    output logic [WID-1:0]   o,
    output logic             o_vld,
    input  logic [DLY_W-1:0] cfg_dly,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic [DLY_W-1:0] cur_dly,
    output logic             busy
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [DLY_W-1:0] r_cur_dly;
    logic [DLY_W-1:0] r_pend_dly;
    logic [DLY_W-1:0] r_fill_cnt;
    logic [DLY_W-1:0] w_clamped;
    logic [DLY_W-1:0] w_fill_inc;
    logic             w_fill_done;
    logic             w_shift;
    logic             w_flush;
    logic             w_tap_vld;

    assign w_clamped  = DLY_W'(clamp_dly(32'(cfg_dly), MAX_DLY));
    assign w_fill_inc = r_fill_cnt + DLY_W'(1);
    // Leave FILL on the ce that lands the first refill sample on the tap.
    assign w_fill_done = ce && (w_fill_inc == r_cur_dly);

    // State register; reset enters FILL so the line refills to DEF_DLY.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StFill;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StRun:   if (cfg_valid) w_state_nxt = StFlush;
            StFlush: w_state_nxt = StFill;
            StFill:  if (w_fill_done) w_state_nxt = StRun;
            default: w_state_nxt = StFill;
        endcase
    end

    // Outputs and line controls decoded from the current state.
    always_comb begin
        cfg_ready = (r_state == StRun);
        busy      = (r_state != StRun);
        w_flush   = (r_state == StFlush);
        w_shift   = ce && (r_state != StFlush);
        o_vld     = w_tap_vld && (r_state == StRun);
    end

    // Delay bookkeeping: latch request, apply it in FLUSH, count refill ce's.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur_dly  <= DLY_W'(DEF_DLY);
            r_pend_dly <= DLY_W'(DEF_DLY);
            r_fill_cnt <= '0;
        end else begin
            case (r_state)
                StRun: begin
                    if (cfg_valid) r_pend_dly <= w_clamped;
                end
                StFlush: begin
                    r_cur_dly  <= r_pend_dly;
                    r_fill_cnt <= '0;
                end
                StFill: begin
                    if (ce) r_fill_cnt <= w_fill_inc;
                end
                default: ;
            endcase
        end
    end

    assign cur_dly = r_cur_dly;

    delay_tap_line #(
        .WID     (WID),
        .MAX_DLY (MAX_DLY),
        .DLY_W   (DLY_W)
    ) u_line (
        .clk     (clk),
        .rst     (rst),
        .i_shift (w_shift),
        .i_flush (w_flush),
        .i_data  (i),
        .i_vld   (i_vld),
        .i_sel   (r_cur_dly),
        .o_data  (o),
        .o_vld   (w_tap_vld)
    );

endmodule
